pipeline_hazard_controller: RTL
===============================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Detects load-use and RAW
//  hazards between ID and EX/MEM, drives the ID/EX bubble (id_shouldStall), PC and IF/ID
//  write enables, and the IF/ID flush on taken branches. Freezes the whole pipe while data
//  memory is not ready, with a timeout to a sticky error state. Keeps saturating stall counters.
// PARAMETERS
//  FORWARDING   1   1: EX/MEM forwarding exists, only load-use stalls; 0: any RAW vs EX or MEM stalls
//  MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before ERROR (>=2)
//  CNT_W        16  width of the stall counters
// PORTS
//  clock                   in   1   pipeline clock
//  reset                   in   1   reset, synchronous, active-high
//  id_rs / id_rt           in   5   source register addresses of instruction in ID
//  id_usesRs / id_usesRt   in   1   ID instruction actually reads rs / rt
//  id_branchTaken          in   1   branch/jump resolved taken in ID
//  ex_shouldWriteRegister  in   1   EX instruction writes GPR
//  ex_registerWriteAddress in   5   EX destination
//  ex_isLoad               in   1   EX instruction is a load (memory-to-register)
//  mem_shouldWriteRegister in   1   MEM instruction writes GPR
//  mem_registerWriteAddress in  5   MEM destination
//  mem_request / mem_ready in   1   MEM-stage data memory access / completion
//  pc_writeEnable          out  1   PC may update
//  ifId_writeEnable        out  1   IF/ID may load
//  ifId_flush              out  1   IF/ID loads a NOP
//  id_shouldStall          out  1   ID/EX loads a bubble
//  pipe_hold               out  1   ID/EX, EX/MEM hold; MEM/WB loads bubble
//  mem_error               out  1   sticky memory timeout
//  loadUseStalls/memStalls out CNT_W saturating event counters (registered)
// BEHAVIOUR
//  - State (registered): RUN, MEM_WAIT, ERROR. Wait counter, stall counters registered.
//  - Stall outputs combinational from inputs + state; same-cycle effect.
//  - Hazard match: usesX && addr!=0 && addr==dest && destWrites. Register $0 never hazards.
//  - loadHaz = ex_isLoad && match(EX). FORWARDING=0: haz = match(EX)||match(MEM); else haz=loadHaz.
//  - Priority: reset > ERROR > memory freeze > hazard > branch flush > normal.
//  - Reset (clock edge with reset=1): state RUN, counters 0, mem_error 0. While reset high:
//    pc_writeEnable=0, ifId_writeEnable=0, ifId_flush=1, id_shouldStall=1, pipe_hold=0.
//  - Normal: pc_we=1, ifId_we=1, flush=0, stall=0, hold=0.
//  - Memory freeze (RUN with mem_request&&!mem_ready, or MEM_WAIT with !mem_ready): pc_we=0,
//    ifId_we=0, hold=1, stall=0, flush=0. RUN->MEM_WAIT at that edge, waitCnt=1.
//  - MEM_WAIT: mem_ready -> RUN, outputs normal/hazard rules that cycle. Else waitCnt++;
//    waitCnt==MEM_TIMEOUT-1 with !mem_ready -> ERROR. memStalls++ each frozen cycle.
//  - ERROR: all as freeze, mem_error=1, exits only by reset.
//  - Hazard (not frozen): stall=1, pc_we=0, ifId_we=0, flush=0. loadUseStalls++ if loadHaz.
//    With FORWARDING=1 a load-use lasts exactly 1 cycle (load then in MEM).
//  - Taken branch with hazard: stall wins, flush suppressed; branch re-resolves next cycle.
//  - Taken branch, no hazard/freeze: ifId_flush=1, pc_we=1, ifId_we=1.
//  - Counters saturate at all-ones; never wrap.
// STRUCTURE
//  - Shared package: state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2), REG_ZERO=5'd0.
//  - Sub-module hazard_comparator (addr/uses/dest/writes -> match), instantiated 4x.
//  - FSM + wait counter + stall counters in this module; outputs in one combinational block.
// TESTING
//  - lw $2 in EX (ex_isLoad=1, dest 2), ID add uses rs=2 -> 1 cycle stall=1, pc_we=0, loadUseStalls=1.
//  - Same with dest $0 -> no stall; FORWARDING=0 with MEM dest 3 == id_rt 3 -> stall=1.
//  - id_branchTaken=1 no hazard -> flush=1; with load-use hazard -> stall=1, flush=0 that cycle.
//  - mem_request=1, mem_ready low 3 cycles -> hold=1 for 3 cycles, memStalls=3, back to RUN.
//  - mem_ready never rises, MEM_TIMEOUT=16 -> ERROR after 16 frozen cycles, mem_error=1 until reset.
//  - Reset mid-MEM_WAIT -> next cycle RUN, counters 0, reset output values during reset.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer state
// encoding and the hard-wired zero register address.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hc_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_comparator.sv
// Compares one ID source operand against one downstream destination.
// Register $0 is hard-wired to zero, so it never creates a dependency.
module hazard_comparator
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [4:0] src_addr,
    input  logic       src_used,
    input  logic [4:0] dest_addr,
    input  logic       dest_writes,
    output logic       match
);

    assign match = src_used && (src_addr != REG_ZERO) &&
                   (src_addr == dest_addr) && dest_writes;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: detects RAW and load-use
// hazards, freezes the pipe while data memory is busy (with a timeout into a
// sticky error state) and keeps saturating stall statistics.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int FORWARDING  = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_usesRs,
    input  logic             id_usesRt,
    input  logic             id_branchTaken,
    input  logic             ex_shouldWriteRegister,
    input  logic [4:0]       ex_registerWriteAddress,
    input  logic             ex_isLoad,
    input  logic             mem_shouldWriteRegister,
    input  logic [4:0]       mem_registerWriteAddress,
    input  logic             mem_request,
    input  logic             mem_ready,
    output logic             pc_writeEnable,
    output logic             ifId_writeEnable,
    output logic             ifId_flush,
    output logic             id_shouldStall,
    output logic             pipe_hold,
    output logic             mem_error,
    output logic [CNT_W-1:0] loadUseStalls,
    output logic [CNT_W-1:0] memStalls
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hc_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  load_use_stalls_q, load_use_stalls_d;
    logic [CNT_W-1:0]  mem_stalls_q, mem_stalls_d;
    logic              mem_error_q, mem_error_d;

    logic rs_ex_match, rt_ex_match, rs_mem_match, rt_mem_match;
    logic load_haz, raw_haz, hazard;
    logic mem_freeze, frozen;

    hazard_comparator u_rs_ex (
        .src_addr    (id_rs),
        .src_used    (id_usesRs),
        .dest_addr   (ex_registerWriteAddress),
        .dest_writes (ex_shouldWriteRegister),
        .match       (rs_ex_match)
    );

    hazard_comparator u_rt_ex (
        .src_addr    (id_rt),
        .src_used    (id_usesRt),
        .dest_addr   (ex_registerWriteAddress),
        .dest_writes (ex_shouldWriteRegister),
        .match       (rt_ex_match)
    );

    hazard_comparator u_rs_mem (
        .src_addr    (id_rs),
        .src_used    (id_usesRs),
        .dest_addr   (mem_registerWriteAddress),
        .dest_writes (mem_shouldWriteRegister),
        .match       (rs_mem_match)
    );

    hazard_comparator u_rt_mem (
        .src_addr    (id_rt),
        .src_used    (id_usesRt),
        .dest_addr   (mem_registerWriteAddress),
        .dest_writes (mem_shouldWriteRegister),
        .match       (rt_mem_match)
    );

    // Classify the current hazard and whether memory is holding the pipe.
    always_comb begin
        load_haz = ex_isLoad && (rs_ex_match || rt_ex_match);
        raw_haz  = rs_ex_match || rt_ex_match || rs_mem_match || rt_mem_match;
        hazard   = (FORWARDING != 0) ? load_haz : raw_haz;
        mem_freeze = ((state_q == ST_RUN) && mem_request && !mem_ready) ||
                     ((state_q == ST_MEM_WAIT) && !mem_ready);
        frozen   = mem_freeze || (state_q == ST_ERROR);
    end

    // Pipeline control outputs; reset, then freeze, then stall, then flush.
    always_comb begin
        pc_writeEnable   = 1'b1;
        ifId_writeEnable = 1'b1;
        ifId_flush       = 1'b0;
        id_shouldStall   = 1'b0;
        pipe_hold        = 1'b0;
        if (reset) begin
            pc_writeEnable   = 1'b0;
            ifId_writeEnable = 1'b0;
            ifId_flush       = 1'b1;
            id_shouldStall   = 1'b1;
        end else if (frozen) begin
            pc_writeEnable   = 1'b0;
            ifId_writeEnable = 1'b0;
            pipe_hold        = 1'b1;
        end else if (hazard) begin
            pc_writeEnable   = 1'b0;
            ifId_writeEnable = 1'b0;
            id_shouldStall   = 1'b1;
        end else if (id_branchTaken) begin
            ifId_flush       = 1'b1;
        end
    end

    // Next-state logic for the memory-wait sequencer and the statistics.
    always_comb begin
        state_d           = state_q;
        wait_cnt_d        = wait_cnt_q;
        mem_error_d       = mem_error_q;
        load_use_stalls_d = load_use_stalls_q;
        mem_stalls_d      = mem_stalls_q;

        case (state_q)
            ST_RUN: begin
                if (mem_request && !mem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d     = ST_ERROR;
                    mem_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                state_d     = ST_ERROR;
                mem_error_d = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (mem_freeze && (mem_stalls_q != {CNT_W{1'b1}})) begin
            mem_stalls_d = mem_stalls_q + CNT_W'(1);
        end
        if (!frozen && load_haz && (load_use_stalls_q != {CNT_W{1'b1}})) begin
            load_use_stalls_d = load_use_stalls_q + CNT_W'(1);
        end
    end

    // Register sequencer state and statistics; synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= ST_RUN;
            wait_cnt_q        <= '0;
            mem_error_q       <= 1'b0;
            load_use_stalls_q <= '0;
            mem_stalls_q      <= '0;
        end else begin
            state_q           <= state_d;
            wait_cnt_q        <= wait_cnt_d;
            mem_error_q       <= mem_error_d;
            load_use_stalls_q <= load_use_stalls_d;
            mem_stalls_q      <= mem_stalls_d;
        end
    end

    assign mem_error     = mem_error_q;
    assign loadUseStalls = load_use_stalls_q;
    assign memStalls     = mem_stalls_q;

endmodule
